mips_run_ctrl: RTL

Synthesizable run controller for the MIPS pipeline. It replaces fixed testbench delays with a parametrised sequence: hold the pipeline in reset for a set number of cycles, run it for a bounded number of cycles, then halt. It drives the pipeline's reset and clock-enable. It also supports halt-on-request, restart, and an optional single-step mode. It sits between the top-level clock/reset and the `PIPELINE` instance.

---
 rtl/mips_run_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mips_run_ctrl.sv
// -----------------------------------------------------------------------------
// mips_run_ctrl
// Run controller for the MIPS pipeline. It holds the pipeline in reset for
// INIT_CYCLES clocked cycles, then lets it run for RUN_CYCLES enabled cycles
// (0 = unlimited) before halting. It also supports halt-on-request and restart
// from DONE, plus an optional single-step mode.
//
// Optional feature macro: MIPS_RUN_CTRL_STEP_EN
//   defined   : STEP state and step edge detector exist; step_mode picks STEP
//               when INIT ends.
//   undefined : step_mode/step are ignored, INIT always exits to RUN.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   begin/restart a run (IDLE and DONE only)
//   step_mode  in   select single-step mode at the INIT->run transition
//   step       in   single-step request, rising edge grants one enabled cycle
//   halt_req   in   stop the run (RUN and STEP only)
//   cpu_rst    out  pipeline reset
//   cpu_en     out  pipeline clock-enable
//   cycle_cnt  out  enabled cycles counted in RUN/STEP
//   state      out  IDLE=0 INIT=1 RUN=2 STEP=3 DONE=4
//   done       out  high in DONE
// -----------------------------------------------------------------------------
module mips_run_ctrl #(
    parameter int unsigned INIT_CYCLES = 5,
    parameter int unsigned RUN_CYCLES  = 24,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic             halt_req,
    output logic             cpu_rst,
    output logic             cpu_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [2:0]       state,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_RUN  = 3'd2,
        S_STEP = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam int unsigned CNT_W1 = CNT_W + 1;

    // Init counter is loaded with INIT_CYCLES-1 and INIT exits when it hits 0.
    localparam logic [CNT_W-1:0] INIT_LOAD =
        (INIT_CYCLES == 0) ? '0 : CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W1-1:0] RUN_LIM = CNT_W1'(RUN_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
    logic             step_pulse_q;
    state_e           run_entry;
    logic [CNT_W-1:0] cnt_sat;
    logic [CNT_W1-1:0] cnt_inc;
    logic             budget_hit;

`ifdef MIPS_RUN_CTRL_STEP_EN
    logic step_q;

    // Registered rising edge of step: one enabled cycle per edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q       <= 1'b0;
            step_pulse_q <= 1'b0;
        end else begin
            step_q       <= step;
            step_pulse_q <= step & ~step_q;
        end
    end

    assign run_entry = step_mode ? S_STEP : S_RUN;
`else
    logic unused_step_inputs;

    assign unused_step_inputs = step_mode ^ step;
    assign step_pulse_q       = 1'b0;
    assign run_entry          = S_RUN;
`endif

    // Saturating increment; with a nonzero budget the count never reaches the top.
    assign cnt_sat    = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
    assign cnt_inc    = CNT_W1'(cycle_cnt_q) + CNT_W1'(1);
    assign budget_hit = (RUN_CYCLES != 0) && (cnt_inc == RUN_LIM);

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cycle_cnt_q <= '0;
            init_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            init_cnt_q  <= init_cnt_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        init_cnt_d  = init_cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    cycle_cnt_d = '0;
                    init_cnt_d  = INIT_LOAD;
                    state_d     = (INIT_CYCLES == 0) ? run_entry : S_INIT;
                end
            end
            S_INIT: begin
                if (init_cnt_q == '0) begin
                    state_d = run_entry;
                end else begin
                    init_cnt_d = init_cnt_q - CNT_W'(1);
                end
            end
            S_RUN: begin
                cycle_cnt_d = cnt_sat;
                if (halt_req || budget_hit) begin
                    state_d = S_DONE;
                end
            end
            S_STEP: begin
                // Only the granted cycle counts toward the budget.
                if (step_pulse_q) begin
                    cycle_cnt_d = cnt_sat;
                    if (budget_hit) begin
                        state_d = S_DONE;
                    end
                end
                if (halt_req) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode from registered state and step pulse.
    assign cpu_rst   = (state_q == S_IDLE) || (state_q == S_INIT);
    assign cpu_en    = (state_q == S_INIT) || (state_q == S_RUN) ||
                       ((state_q == S_STEP) && step_pulse_q);
    assign done      = (state_q == S_DONE);
    assign cycle_cnt = cycle_cnt_q;
    assign state     = state_q;

endmodule
